// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle for the sequential divider
//
// Purpose: groups the divider's request operands and registered results so
// the requester (master) and the divider (slave) connect through one port.
// Signals:
//   start      master->slave  request, sampled while busy=0
//   isSigned   master->slave  1 = two's-complement divide
//   dividend   master->slave  numerator
//   divisor    master->slave  denominator
//   quotient   slave->master  registered quotient
//   remainder  slave->master  registered remainder
//   busy       slave->master  iteration sequence in progress
//   done       slave->master  one-cycle completion pulse
//   divByZero  slave->master  last completed operation had divisor 0
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (
    output start, isSigned, dividend, divisor,
    input  quotient, remainder, busy, done, divByZero
  );

  modport slave (
    input  start, isSigned, dividend, divisor,
    output quotient, remainder, busy, done, divByZero
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-subtract divider, one bit per clock
//
// Purpose: signed/unsigned WIDTH-bit divide over WIDTH iterations. Results
// are registered only on completion, so outputs never show partial values.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_if.slave (start/isSigned/dividend/divisor in,
//          quotient/remainder/busy/done/divByZero out)
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             dd_neg, ds_neg;
  logic [WIDTH-1:0] dd_mag, ds_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Magnitudes fit in WIDTH unsigned bits even for the most negative value.
  assign dd_neg = bus.isSigned & bus.dividend[WIDTH-1];
  assign ds_neg = bus.isSigned & bus.divisor[WIDTH-1];
  assign dd_mag = dd_neg ? -bus.dividend : bus.dividend;
  assign ds_mag = ds_neg ? -bus.divisor  : bus.divisor;

  // One restoring step: shift next dividend bit into the partial remainder
  // and subtract; a borrow (trial MSB) means keep the shifted value.
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = dd_mag;
          dvs_d     = ds_mag;
          neg_quo_d = dd_neg ^ ds_neg;
          neg_rem_d = dd_neg;
          dbz_d     = 1'b0;
          if (bus.divisor == '0) begin
            // Divide by zero completes immediately with fixed results.
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          quotient_d  = neg_quo_q ? -step_quo : step_quo;
          remainder_d = neg_rem_q ? -step_rem : step_rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.divByZero = dbz_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed scoreboard bench for seq_divider
module tb_seq_divider;

  logic clk;
  logic rst_n;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(bit sgn, logic [31:0] a, logic [31:0] b);
    exp_t   e;
    longint sa, sb_v, q, r;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 32;
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      q    = sa / sb_v;
      r    = sa % sb_v;
      e.q  = q[31:0]; e.r = r[31:0]; e.dbz = 1'b0; e.lat = 32;
    end
    return e;
  endfunction

  // Called at a negedge; the following posedge is the capture edge. Returns
  // at the negedge right after capture with operands scrambled.
  task automatic drive_start(bit sgn, logic [31:0] a, logic [31:0] b, bit push);
    dif.start    = 1'b1;
    dif.isSigned = sgn;
    dif.dividend = a;
    dif.divisor  = b;
    if (push) sb.push_back(model(sgn, a, b));
    @(negedge clk);
    dif.start    = 1'b0;
    dif.isSigned = $urandom_range(0, 1);
    dif.dividend = $urandom();
    dif.divisor  = $urandom();
  endtask

  // k counts negedges after the capture edge; done is expected at k == lat.
  // inject_k >= 0 pulses a 9/3 start while the divider should be busy.
  task automatic wait_done(string tag, int inject_k);
    int   k = 0;
    int   busy_n = 0;
    bit   seen = 0;
    exp_t e;
    while (k <= 100) begin
      dif.start = (k == inject_k);
      if (k == inject_k) begin
        dif.isSigned = 1'b0; dif.dividend = 32'd9; dif.divisor = 32'd3;
      end
      if (dif.done) begin
        seen = 1;
        break;
      end
      if (dif.busy) busy_n++;
      @(negedge clk);
      k++;
    end
    dif.start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(k), 32'(e.lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(e.lat));
        chk({tag, " quotient"}, dif.quotient, e.q);
        chk({tag, " remainder"}, dif.remainder, e.r);
        chk({tag, " divByZero"}, 32'(dif.divByZero), 32'(e.dbz));
      end
    end
  endtask

  task automatic op(string tag, bit sgn, logic [31:0] a, logic [31:0] b);
    drive_start(sgn, a, b, 1'b1);
    wait_done(tag, -1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(dif.done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.isSigned = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst quotient", dif.quotient, 32'd0);
    chk("rst remainder", dif.remainder, 32'd0);
    chk("rst busy", 32'(dif.busy), 32'd0);
    chk("rst done", 32'(dif.done), 32'd0);
    chk("rst dbz", 32'(dif.divByZero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op("u100_7", 1'b0, 32'd100, 32'd7);
    op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    op("div0_u", 1'b0, 32'h1234_5678, 32'd0);
    op("div0_s", 1'b1, 32'h8765_4321, 32'd0);
    op("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    op("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    op("dbz_clear", 1'b0, 32'd5, 32'd5);

    // Ignored mid-run start, then back-to-back start in the DONE cycle.
    drive_start(1'b0, 32'd50, 32'd5, 1'b1);
    wait_done("u50_5", 10);
    drive_start(1'b0, 32'd9, 32'd3, 1'b1);
    wait_done("b2b_9_3", -1);
    @(negedge clk);
    chk("b2b sb_empty", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd13;
      op("rand", i[0], ra, rb);
    end
    op("u_rem", 1'b0, 32'd1003, 32'd10);

    // Asynchronous reset in the middle of a run.
    drive_start(1'b0, 32'd77, 32'd5, 1'b0);
    repeat (16) @(negedge clk);
    rst_n     = 1'b0;
    dif.start = 1'b1;
    dif.divisor  = 32'd0;
    #1;
    chk("arst quotient", dif.quotient, 32'd0);
    chk("arst remainder", dif.remainder, 32'd0);
    chk("arst busy", 32'(dif.busy), 32'd0);
    chk("arst done", 32'(dif.done), 32'd0);
    chk("arst dbz", 32'(dif.divByZero), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst no_done", 32'(dif.done), 32'd0);
    end
    rst_n     = 1'b1;
    dif.start = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("post_rst idle", 32'({dif.busy, dif.done}), 32'd0);
    end
    op("u1000_10", 1'b0, 32'd1000, 32'd10);
    chk("end sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
